imem_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/byte_assembler.sv | 55 +++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// the frame start marker and the default RAM address width.
package mips_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HDR1,
        HDR2,
        LOAD,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_ADDR_W    = 8;

endpackage

// File: rtl/byte_assembler.sv
// 8-to-32 big-endian word assembler. The first byte of each group of four
// ends up in [31:24]. word_valid pulses for one cycle after the fourth byte
// is taken, and word holds the completed word until the next one completes.
module byte_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [7:0]  lane_reg  [4];
    logic [7:0]  lane_next [4];
    logic [1:0]  cnt_reg;
    logic        word_valid_reg;
    logic [31:0] word_reg;

    // Lane 0 takes the incoming byte; every other lane takes its lower neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign lane_next[gi] = in_data;
            end else begin : g_rest
                assign lane_next[gi] = lane_reg[gi-1];
            end
        end
    endgenerate

    // Shift bytes in, count them, and capture the full word on the fourth one.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < 4; i++) lane_reg[i] <= 8'h00;
            cnt_reg        <= 2'd0;
            word_valid_reg <= 1'b0;
            if (reset) word_reg <= 32'h0;
        end else begin
            word_valid_reg <= 1'b0;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) lane_reg[i] <= lane_next[i];
                cnt_reg <= cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    word_valid_reg <= 1'b1;
                    word_reg       <= {lane_next[3], lane_next[2], lane_next[1], lane_next[0]};
                end
            end
        end
    end

    assign word_valid = word_valid_reg;
    assign word       = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (SYNC, CNT_HI, CNT_LO,
// 4*N data bytes MSB first), writes the assembled words into the instruction
// RAM and holds the CPU in reset until the image is in.
// Build option: IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte.
// ADDR_W is supported up to 15 (the word count field is 16 bits).
module imem_loader
    import mips_pkg::*;
#(
    parameter int         ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int          CNT_W       = ADDR_W + 1;
    localparam int          BYTE_W      = ADDR_W + 3;
    localparam logic [16:0] MAX_WORDS_W = 17'(2**ADDR_W);

    loader_state_t     state_reg, state_next;
    logic [7:0]        cnt_hi_reg;
    logic [CNT_W-1:0]  n_reg;
    logic [BYTE_W-1:0] byte_cnt_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [15:0]       hdr_n;
    logic [BYTE_W-1:0] total_bytes;
    logic              load_full;
    logic              accept;
    logic              word_valid;
    logic [31:0]       word;

    assign hdr_n       = {cnt_hi_reg, rx_data};
    assign total_bytes = {n_reg, 2'b00};
    assign load_full   = (byte_cnt_reg == total_bytes);
    assign accept      = rx_valid && rx_ready;

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] xor_reg;
    logic       last_byte;
    assign last_byte = (BYTE_W'(byte_cnt_reg + 1'b1) == total_bytes);
`else
    logic       last_write;
    assign last_write = word_valid && ({1'b0, idx_reg} == (n_reg - 1'b1));
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_reg <= SYNC;
        else       state_reg <= state_next;
    end

    // Next-state and handshake decode; start overrides everything.
    always_comb begin
        state_next = state_reg;
        rx_ready   = 1'b0;
        case (state_reg)
            SYNC, HDR1, HDR2: rx_ready = 1'b1;
            LOAD:             rx_ready = !load_full;
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK:              rx_ready = 1'b1;
`endif
            default:          rx_ready = 1'b0;
        endcase
        if (start) rx_ready = 1'b0;

        if (start) begin
            state_next = SYNC;
        end else begin
            case (state_reg)
                SYNC: if (accept && rx_data == SYNC_BYTE) state_next = HDR1;
                HDR1: if (accept) state_next = HDR2;
                HDR2: if (accept) begin
                    if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, hdr_n} > MAX_WORDS_W) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD;
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                LOAD: if (accept && last_byte) state_next = CHK;
                CHK:  if (accept) state_next = (rx_data == xor_reg) ? DONE : ERR;
`else
                LOAD: if (last_write) state_next = DONE;
`endif
                default: state_next = state_reg;
            endcase
        end
    end

    // Header latch, byte/word counters and running checksum.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            cnt_hi_reg   <= 8'h00;
            n_reg        <= '0;
            byte_cnt_reg <= '0;
            idx_reg      <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            xor_reg      <= 8'h00;
`endif
        end else begin
            if (state_reg == HDR1 && accept) cnt_hi_reg <= rx_data;
            if (state_reg == HDR2 && accept) n_reg <= hdr_n[CNT_W-1:0];
            if (state_reg == LOAD && accept) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                xor_reg      <= xor_reg ^ rx_data;
`endif
            end
            if (word_valid) idx_reg <= idx_reg + 1'b1;
        end
    end

    byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (start),
        .in_valid   (accept && state_reg == LOAD),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign wr_en    = word_valid;
    assign wr_addr  = idx_reg;
    assign wr_data  = word;
    assign done     = (state_reg == DONE);
    assign error    = (state_reg == ERR);
    assign cpu_hold = (state_reg != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected RAM writes are queued when a
// frame is driven and compared as wr_en pulses appear.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, wr_en, cpu_hold, done, error;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] frame_q[$];
    int          checks   = 0;
    int          failures = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Write monitor: every wr_en pulse must match the head of the queue.
    always @(negedge clock) begin : mon
        wr_t e;
        if (reset === 1'b0 && wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected addr=%0d data=%h expected none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    failures++;
                    $display("FAIL wr_match got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%h ok", wr_addr, wr_data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rx_ready === 1'b1) got = 1;
            @(posedge clock);
            if (!got) begin
                @(negedge clock);
                #1;
            end
        end
        #1;
        rx_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL byte_accept byte=%h not accepted within 20 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_ready got=%b expected=0", rx_ready);
        end
        @(negedge clock);
        start    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++;
        if ({done, error, cpu_hold, rx_ready} !== 4'b0011) begin
            failures++;
            $display("FAIL start_state got done/err/hold/rdy=%b expected=0011",
                     {done, error, cpu_hold, rx_ready});
        end
    endtask

    // Drive a complete frame built from frame_q and check completion timing.
    task automatic send_frame(input int gap);
        logic [15:0] n;
        logic [7:0]  x;
        logic [31:0] w;
        n = 16'(frame_q.size());
        x = 8'h00;
        for (int i = 0; i < frame_q.size(); i++)
            exp_q.push_back('{addr: ADDR_W'(i), data: frame_q[i]});
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < frame_q.size(); i++) begin
            w = frame_q[i];
            for (int b = 3; b >= 0; b--) begin
                if (gap > 0) idle(gap);
                send_byte(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(x);
`else
        if (n != 16'd0) begin
            @(negedge clock);
            checks++;
            if ({wr_en, done, cpu_hold} !== 3'b101) begin
                failures++;
                $display("FAIL last_write_cycle got wr/done/hold=%b expected=101", {wr_en, done, cpu_hold});
            end
        end
`endif
        @(negedge clock);
        checks++;
        if ({done, cpu_hold, rx_ready, error} !== 4'b1000) begin
            failures++;
            $display("FAIL frame_done got done/hold/rdy/err=%b expected=1000",
                     {done, cpu_hold, rx_ready, error});
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL writes_missing got pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        $display("frame n=%0d gap=%0d complete", n, gap);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, wr_en, cpu_hold, done, error} !== 5'b10100) begin
            failures++;
            $display("FAIL reset_flags got rdy/wr/hold/done/err=%b expected=10100",
                     {rx_ready, wr_en, cpu_hold, done, error});
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_wr got addr=%0d data=%h expected 0/0", wr_addr, wr_data);
        end
        $display("reset checked");
    endtask

    task automatic test_basic(input int gap);
        pulse_start();
        frame_q = '{32'hDEADBEEF, 32'h0000002A};
        send_frame(gap);
    endtask

    task automatic test_sync_discard();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        frame_q = '{32'h12345678};
        send_frame(0);
    endtask

    task automatic test_oversize();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clock);
        checks++;
        if ({error, rx_ready, cpu_hold, done} !== 4'b1010) begin
            failures++;
            $display("FAIL oversize got err/rdy/hold/done=%b expected=1010",
                     {error, rx_ready, cpu_hold, done});
        end
        $display("oversize header checked");
    endtask

    task automatic test_start_mid();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        frame_q = '{32'hCAFEBABE};
        send_frame(0);
    endtask

    task automatic test_zero();
        pulse_start();
        frame_q.delete();
        send_frame(0);
    endtask

    task automatic test_max();
        pulse_start();
        frame_q.delete();
        for (int i = 0; i < 2**ADDR_W; i++) frame_q.push_back($urandom());
        send_frame(0);
    endtask

`ifdef IMEM_LOADER_CHKSUM_EN
    task automatic test_chksum();
        pulse_start();
        frame_q = '{32'h01020408};
        send_frame(0);
        pulse_start();
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h01020408});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        @(negedge clock);
        checks++;
        if ({error, cpu_hold, done, rx_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL chksum_bad got err/hold/done/rdy=%b expected=1100",
                     {error, cpu_hold, done, rx_ready});
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL chksum_write got pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        $display("bad checksum checked");
    endtask
`endif

    initial begin
        test_reset();
        test_basic(0);
        test_sync_discard();
        test_oversize();
        test_start_mid();
        test_basic(1);
        test_zero();
        test_max();
`ifdef IMEM_LOADER_CHKSUM_EN
        test_chksum();
`endif
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
